// File: rtl/demux_bbm_if.sv
// rtl/demux_bbm_if.sv - request/data/lane bundle between the step generator and demux_bbm
interface demux_bbm_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 1
);
  localparam int SEL_W = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

  logic [SEL_W-1:0]          select_in;
  logic                      select_valid_in;
  logic [WIDTH-1:0]          sig_in;
  logic [CHANNELS*WIDTH-1:0] r_sig_out;
  logic [CHANNELS-1:0]       r_active_out;
  logic                      r_busy_out;
  logic                      r_error_out;

  modport master (
    output select_in, select_valid_in, sig_in,
    input  r_sig_out, r_active_out, r_busy_out, r_error_out
  );

  modport slave (
    input  select_in, select_valid_in, sig_in,
    output r_sig_out, r_active_out, r_busy_out, r_error_out
  );
endinterface

// File: rtl/demux_bbm.sv
// rtl/demux_bbm.sv - registered 1-to-N demux with break-before-make dead time
// DEMUX_HOLD_EN: deselected lanes freeze at their last value instead of returning to IDLE.
module demux_bbm #(
  parameter int                 CHANNELS = 3,
  parameter int                 WIDTH    = 1,
  parameter int                 DEADTIME = 4,
  parameter logic [WIDTH-1:0]   IDLE     = '0
) (
  input  logic         clk_in,
  input  logic         reset_in,
  demux_bbm_if.slave   bus
);
  localparam int SEL_W = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (DEADTIME > 0) ? (($clog2(DEADTIME + 1) > 1) ? $clog2(DEADTIME + 1) : 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  typedef enum logic {ST_CONN, ST_DEAD} state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          cur_q, cur_d;
  logic [SEL_W-1:0]          nxt_q, nxt_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0]       active_q, active_d;
  logic                      busy_q, busy_d;
  logic                      error_q, error_d;

  logic                      conn;
  logic [SEL_W-1:0]          lane;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    error_d = 1'b0;
    conn    = 1'b0;
    lane    = cur_q;

    case (state_q)
      ST_CONN: begin
        conn = 1'b1;
        if (bus.select_valid_in) begin
          if (int'(bus.select_in) >= CHANNELS) begin
            error_d = 1'b1;
          end else if (bus.select_in != cur_q) begin
            if (DEADTIME == 0) begin
              cur_d = bus.select_in;
              lane  = bus.select_in;
            end else begin
              // Old lane is released at the accepting edge; the new one waits out the dead time.
              state_d = ST_DEAD;
              nxt_d   = bus.select_in;
              cnt_d   = CNT_LOAD;
              conn    = 1'b0;
            end
          end
        end
      end
      ST_DEAD: begin
        if (cnt_q == '0) begin
          state_d = ST_CONN;
          cur_d   = nxt_q;
          lane    = nxt_q;
          conn    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_CONN;
    endcase

`ifdef DEMUX_HOLD_EN
    sig_d = sig_q;
`else
    sig_d = {CHANNELS{IDLE}};
`endif
    active_d = '0;
    if (conn) begin
      sig_d[int'(lane)*WIDTH +: WIDTH] = bus.sig_in;
      active_d = {{(CHANNELS-1){1'b0}}, 1'b1} << lane;
    end
    busy_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= ST_CONN;
      cur_q    <= '0;
      nxt_q    <= '0;
      cnt_q    <= '0;
      sig_q    <= {CHANNELS{IDLE}};
      active_q <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign bus.r_sig_out    = sig_q;
  assign bus.r_active_out = active_q;
  assign bus.r_busy_out   = busy_q;
  assign bus.r_error_out  = error_q;
endmodule

// File: tb/tb_demux_bbm.sv
// tb/tb_demux_bbm.sv - directed scoreboard bench for demux_bbm (CHANNELS=3, WIDTH=1, DEADTIME=4)
module tb_demux_bbm;
`ifdef DEMUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] sig;
    logic [2:0] act;
    logic       busy;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  demux_bbm_if #(.CHANNELS(3), .WIDTH(1)) bus ();

  demux_bbm #(.CHANNELS(3), .WIDTH(1), .DEADTIME(4), .IDLE(1'b0)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus.slave)
  );

  task automatic check(input string tag, input exp_t exp);
    exp_t obs;
    obs = '{bus.r_sig_out, bus.r_active_out, bus.r_busy_out, bus.r_error_out};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed sig=%b act=%b busy=%b err=%b expected sig=%b act=%b busy=%b err=%b",
             tag, obs.sig, obs.act, obs.busy, obs.err, exp.sig, exp.act, exp.busy, exp.err);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare it after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] sel, input logic s,
                      input logic [2:0] esig, input logic [2:0] esig_hold,
                      input logic [2:0] eact, input logic ebusy, input logic eerr);
    exp_t e;
    bus.select_valid_in = v;
    bus.select_in       = sel;
    bus.sig_in          = s;
    sb.push_back('{HOLD ? esig_hold : esig, eact, ebusy, eerr});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.select_valid_in = 1'b0;
    bus.select_in       = 2'd0;
    bus.sig_in          = 1'b1;
    #2;
    check("reset_async", '{3'b000, 3'b000, 1'b0, 1'b0});
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", '{3'b000, 3'b000, 1'b0, 1'b0});
    rst = 1'b0;
    step("reset_release", 0, 0, 1, 3'b001, 3'b001, 3'b001, 0, 0);

    step("sw2_e0", 1, 2, 1, 3'b000, 3'b001, 3'b000, 1, 0);
    for (int i = 1; i < 4; i++)
      step("sw2_dead", 0, 0, 1, 3'b000, 3'b001, 3'b000, 1, 0);
    step("sw2_e4", 0, 0, 1, 3'b100, 3'b101, 3'b100, 0, 0);

    step("sw0_e0", 1, 0, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    for (int i = 1; i < 4; i++)
      step("sw0_dead", 0, 1, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    step("sw0_e4", 0, 0, 1, 3'b001, 3'b101, 3'b001, 0, 0);

    step("drop_e0", 1, 2, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    step("drop_e1", 0, 0, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    step("drop_e2", 1, 1, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    step("drop_e3", 0, 0, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    step("drop_e4", 1, 1, 1, 3'b100, 3'b101, 3'b100, 0, 0);
    step("drop_e5", 0, 0, 1, 3'b100, 3'b101, 3'b100, 0, 0);

    step("bad_sel", 1, 3, 1, 3'b100, 3'b101, 3'b100, 0, 1);
    step("bad_after", 0, 0, 0, 3'b000, 3'b001, 3'b100, 0, 0);
    step("same_sel", 1, 2, 1, 3'b100, 3'b101, 3'b100, 0, 0);
    step("same_after", 0, 0, 1, 3'b100, 3'b101, 3'b100, 0, 0);

    step("rst_e0", 1, 1, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    step("rst_e1", 0, 0, 1, 3'b000, 3'b101, 3'b000, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_dead", '{3'b000, 3'b000, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("rst_mid_held", '{3'b000, 3'b000, 1'b0, 1'b0});
    rst = 1'b0;
    step("rst_reconnect", 0, 0, 1, 3'b001, 3'b001, 3'b001, 0, 0);

    step("hold_pre", 0, 0, 1, 3'b001, 3'b001, 3'b001, 0, 0);
    step("hold_e0", 1, 1, 0, 3'b000, 3'b001, 3'b000, 1, 0);
    for (int i = 1; i < 4; i++)
      step("hold_dead", 0, 0, 0, 3'b000, 3'b001, 3'b000, 1, 0);
    step("hold_e4", 0, 0, 0, 3'b000, 3'b001, 3'b010, 0, 0);
    step("hold_follow", 0, 0, 1, 3'b010, 3'b011, 3'b010, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_bbm.md
# demux_bbm

Parametrised, registered 1-to-N demultiplexer with break-before-make switching, the successor to the single-bit `mux` block. It routes a WIDTH-bit signal to one of CHANNELS output lanes and inserts a programmable dead time on every channel change, so no two lanes are ever driven from `sig_in` in the same cycle. It sits between the step/direction generator and the per-axis driver lines.

## Interface
- `CHANNELS`, 3: number of output lanes, ≥2.
- `WIDTH`, 1: bits per lane.
- `DEADTIME`, 4: idle cycles inserted on a channel change, 0..255.
- `IDLE`, 0: WIDTH-bit value driven on disconnected lanes.
- Derived `SEL_W` = max(1, $clog2(CHANNELS)).

Ports:
- `clk_in`  in  1  system clock, rising edge.
- `reset_in`  in  1  asynchronous, active-high reset.
- `select_in`  in  SEL_W  requested lane.
- `select_valid_in`  in  1  request strobe, sampled each rising edge.
- `sig_in`  in  WIDTH  data to route.
- `r_sig_out`  out  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- `r_active_out`  out  CHANNELS  one-hot connected lane, or all zero during dead time.
- `r_busy_out`  out  1  dead time in progress.
- `r_error_out`  out  1  one-cycle pulse on a rejected out-of-range select.

## Operation
- Two-state FSM:
  - CONNECTED: the current lane registers `sig_in` every edge, and all other lanes hold IDLE.
  - DEAD: all lanes hold IDLE, and a down-counter of width $clog2(DEADTIME+1) runs.
- Reset values: all lanes IDLE, `r_active_out`=0, `r_busy_out`=0, `r_error_out`=0, current select=0, state CONNECTED with the output connection pending. At the first edge after release, lane 0 takes `sig_in` and `r_active_out`=1.
- A request is accepted when `select_valid_in`=1 and `r_busy_out`=0 at an edge. Call that edge E0.
  - `select_in` ≥ CHANNELS: rejected. `r_error_out`=1 for exactly one cycle and nothing else changes.
  - `select_in` equal to the current lane: no-op. No dead time, no error.
  - DEADTIME=0: switch at E0. The old lane goes IDLE and the new lane takes `sig_in` in the same edge. `r_busy_out` stays 0.
  - Otherwise, at E0 the FSM enters DEAD. All lanes go IDLE, `r_active_out`=0, `r_busy_out`=1, and the counter loads DEADTIME−1.
- In DEAD, the counter decrements each edge. On the edge where the counter is 0, the FSM enters CONNECTED with the new lane: the lane takes `sig_in`, `r_active_out` shows the new lane, and `r_busy_out`=0.
- Requests arriving while `r_busy_out`=1 are dropped. They are not queued and raise no error.
- The new select is latched at E0. Later changes on `select_in` have no effect.

## Timing
- `sig_in` to `r_sig_out` latency: 1 cycle in CONNECTED.
- With a switch accepted at E0 and DEADTIME=D≥1:
  - Lanes are IDLE from E0 through E(D−1), i.e. exactly D cycles.
  - The new lane is valid from E(D).
  - `r_busy_out` is high from E0 to E(D).
  - The earliest next acceptance is E(D+1).
- `r_error_out` is registered and rises at the accepting edge.
- Asserting `reset_in` at any time, including mid-DEAD, forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `DEMUX_HOLD_EN` defined: a deselected lane freezes at its last driven value instead of returning to IDLE. This applies in DEAD and in CONNECTED. Only never-connected lanes and reset use IDLE. Break-before-make still holds: the old lane stops following `sig_in` at E0, and the new lane connects at E(D).
- `DEMUX_HOLD_EN` undefined: behaviour is as described in Operation.

## Test plan
All scenarios use CHANNELS=3, WIDTH=1, DEADTIME=4, IDLE=0.

1. Reset: hold `reset_in`, then release with `sig_in`=1. During reset `r_sig_out`=000. One edge after release, `r_sig_out`=001 and `r_active_out`=001.
2. Switch: `sig_in`=1, request select 2 at E0. `r_sig_out`=000 and `r_busy_out`=1 for E0..E3. At E4, `r_sig_out`=100, `r_active_out`=100, `r_busy_out`=0.
3. Busy drop: start the switch to 2 and request select 1 at E2. The request is ignored; `r_sig_out`=100 at E4 with no error.
4. Invalid and no-op selects: select 3 gives one `r_error_out` pulse with outputs unchanged. Re-selecting the current lane leaves `r_busy_out`=0 with outputs unchanged.
5. Reset during dead time: assert `reset_in` between E1 and E2. Outputs go to reset values at once. After release, lane 0 connects.
6. With `DEMUX_HOLD_EN`: lane 0 carries 1, switch to 1 with `sig_in`=0. Lane 0 stays 1 throughout, and lane 1 becomes 0 at E4.
